// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the fetch port, load/store port and memory-side signals of mem_port_arbiter.
// Latency: none; wiring only.
// Backpressure: stalls flow to requesters, mem_busy flows from memory.
interface mem_port_arbiter_if #(
  parameter int NBITS = 8
);
  logic             f_req;
  logic [NBITS-1:0] f_addr;
  logic [NBITS-1:0] f_rdata;
  logic             f_done;
  logic             f_stall;
  logic             d_req;
  logic             d_we;
  logic [NBITS-1:0] d_addr;
  logic [NBITS-1:0] d_wdata;
  logic [NBITS-1:0] d_rdata;
  logic             d_done;
  logic             d_stall;
  logic             mem_req;
  logic             mem_we;
  logic [NBITS-1:0] mem_addr;
  logic [NBITS-1:0] mem_wdata;
  logic [NBITS-1:0] mem_rdata;
  logic             mem_busy;
  logic             err;
  logic             err_port;

  // Arbiter view.
  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_busy,
    output f_rdata, f_done, f_stall, d_rdata, d_done, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, err, err_port
  );

  // Controller plus memory view.
  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_busy,
    input  f_rdata, f_done, f_stall, d_rdata, d_done, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, err, err_port
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between fetch (F) and load/store (D) ports; MEM_ARB_RR_EN selects round-robin.
// Latency: req to done 2 cycles with zero-wait memory, +1 per mem_busy cycle; aborts with err after TIMEOUT busy cycles.
// Backpressure: mem_busy holds the access; requesters see f_stall/d_stall until their done pulse.
module mem_port_arbiter #(
  parameter int NBITS   = 8,
  parameter int TIMEOUT = 15
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, F_ACC, D_ACC} state_t;

  state_t           state_q, next_state;
  logic [CW-1:0]    cnt_q, cnt_next;
  logic             grant_f, grant_d, complete, timeout;
  logic [NBITS-1:0] addr_q, wdata_q, f_rdata_q, d_rdata_q;
  logic             we_q, f_done_q, d_done_q, err_q, err_port_q;

`ifdef MEM_ARB_RR_EN
  // 1 = D port was granted most recently, 0 = F port.
  logic last_grant_q;
`endif

  // Next-state logic: arbitration in IDLE, completion/timeout detection during an access.
  always_comb begin
    next_state = state_q;
    cnt_next   = cnt_q;
    grant_f    = 1'b0;
    grant_d    = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.d_req && bus.f_req) begin
`ifdef MEM_ARB_RR_EN
          if (last_grant_q) grant_f = 1'b1;
          else              grant_d = 1'b1;
`else
          grant_d = 1'b1;
`endif
        end else if (bus.d_req) begin
          grant_d = 1'b1;
        end else if (bus.f_req) begin
          grant_f = 1'b1;
        end
        if (grant_d)      next_state = D_ACC;
        else if (grant_f) next_state = F_ACC;
        if (grant_d || grant_f) cnt_next = '0;
      end
      F_ACC, D_ACC: begin
        if (!bus.mem_busy) begin
          complete   = 1'b1;
          next_state = IDLE;
        end else begin
          // Saturating count so the counter can never wrap back below TIMEOUT.
          cnt_next = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
          if (cnt_next == CW'(TIMEOUT)) begin
            timeout    = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State, wait counter and the done/err pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      f_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      err_q      <= 1'b0;
      err_port_q <= 1'b0;
    end else begin
      state_q  <= next_state;
      cnt_q    <= cnt_next;
      f_done_q <= complete && (state_q == F_ACC);
      d_done_q <= complete && (state_q == D_ACC);
      err_q    <= timeout;
      if (timeout) err_port_q <= (state_q == D_ACC);
    end
  end

  // Latch the granted request so the memory sees stable signals, and capture read data on completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (grant_d) begin
        addr_q  <= bus.d_addr;
        wdata_q <= bus.d_wdata;
        we_q    <= bus.d_we;
      end else if (grant_f) begin
        addr_q <= bus.f_addr;
        we_q   <= 1'b0;
      end
      if (complete && (state_q == F_ACC)) f_rdata_q <= bus.mem_rdata;
      if (complete && (state_q == D_ACC) && !we_q) d_rdata_q <= bus.mem_rdata;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remember which port won the last grant; reset favours F as "last" so D wins the first tie.
  always_ff @(posedge clock) begin
    if (reset)        last_grant_q <= 1'b0;
    else if (grant_d) last_grant_q <= 1'b1;
    else if (grant_f) last_grant_q <= 1'b0;
  end
`endif

  assign bus.mem_req   = (state_q != IDLE);
  assign bus.mem_we    = we_q && (state_q == D_ACC);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.f_rdata   = f_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.f_done    = f_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.err       = err_q;
  assign bus.err_port  = err_port_q;
  assign bus.f_stall   = bus.f_req && !f_done_q;
  assign bus.d_stall   = bus.d_req && !d_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: scoreboard bench for mem_port_arbiter with directed accesses and a busy-cycle memory responder.
// Latency: expected done/err cycles are hand-computed per access.
// Backpressure: the responder holds mem_busy for a programmed number of cycles per access.
module tb_mem_port_arbiter;
  logic clock = 1'b0;
  logic reset;

  mem_port_arbiter_if #(.NBITS(8)) bus ();
  mem_port_arbiter #(.NBITS(8), .TIMEOUT(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         kind;   // 0 = f_done, 1 = d_done, 2 = err
    int         port;   // err_port for kind 2
    int         cyc;
    logic [7:0] val;    // rdata of the affected port
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         busy_len = 0;
  int         busy_seen = 0;
  logic [7:0] rd_xor = 8'h00;
  logic [7:0] f_rd_m = 8'h00;
  logic [7:0] d_rd_m = 8'h00;
  logic       prev_req = 1'b0;
  logic       prev_we = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  logic [7:0] prev_wdata = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int port, input int at, input logic [7:0] val);
    exp_t e;
    e.kind = kind;
    e.port = port;
    e.cyc  = at;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input logic [7:0] rd, input logic ep);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got output kind %0d at cycle %0d expected none", kind, cyc);
      return;
    end
    e = exp_q.pop_front();
    check("sb_kind", kind, e.kind);
    check("sb_cycle", cyc, e.cyc);
    check("sb_rdata", {24'h0, rd}, {24'h0, e.val});
    if (kind == 2) check("sb_err_port", {31'h0, ep}, e.port);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Memory responder: busy for busy_len cycles of each access, data = address ^ rd_xor.
  always @(negedge clock) begin
    if (bus.mem_req) begin
      bus.mem_busy = (busy_seen < busy_len);
      busy_seen++;
    end else begin
      bus.mem_busy = 1'b0;
      busy_seen = 0;
    end
    bus.mem_rdata = bus.mem_addr ^ rd_xor;
  end

  // Monitor: pop the scoreboard on every done/err pulse and check memory-side stability.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (bus.f_done) sb_pop(0, bus.f_rdata, bus.err_port);
      if (bus.d_done) sb_pop(1, bus.d_rdata, bus.err_port);
      if (bus.err)    sb_pop(2, bus.err_port ? bus.d_rdata : bus.f_rdata, bus.err_port);
      if (bus.mem_req && prev_req) begin
        check("stable_addr", {24'h0, bus.mem_addr}, {24'h0, prev_addr});
        check("stable_wdata", {24'h0, bus.mem_wdata}, {24'h0, prev_wdata});
        check("stable_we", {31'h0, bus.mem_we}, {31'h0, prev_we});
      end
    end
    prev_req   = bus.mem_req;
    prev_addr  = bus.mem_addr;
    prev_wdata = bus.mem_wdata;
    prev_we    = bus.mem_we;
  end

  initial begin
    int c;
    reset = 1'b1;
    bus.f_req = 1'b0; bus.f_addr = 8'h00;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 8'h00; bus.d_wdata = 8'h00;
    tick(2);
    check("rst_mem_req", {31'h0, bus.mem_req}, 0);
    check("rst_f_rdata", {24'h0, bus.f_rdata}, 0);
    check("rst_d_rdata", {24'h0, bus.d_rdata}, 0);
    check("rst_err_port", {31'h0, bus.err_port}, 0);
    check("rst_mem_addr", {24'h0, bus.mem_addr}, 0);
    reset = 1'b0;
    tick(1);
    check("idle_no_req", {31'h0, bus.mem_req}, 0);

    // Single zero-wait fetch.
    c = cyc; busy_len = 0; rd_xor = 8'h10 ^ 8'hA5;
    bus.f_addr = 8'h10; bus.f_req = 1'b1;
    push(0, 0, c + 2, 8'hA5); f_rd_m = 8'hA5;
    #1 check("fetch_stall", {31'h0, bus.f_stall}, 1);
    tick(1);
    check("fetch_mem_req", {31'h0, bus.mem_req}, 1);
    check("fetch_mem_addr", {24'h0, bus.mem_addr}, 32'h10);
    check("fetch_mem_we", {31'h0, bus.mem_we}, 0);
    tick(1);
    check("fetch_stall_done", {31'h0, bus.f_stall}, 0);
    bus.f_req = 1'b0;
    tick(1);
    check("fetch_back_idle", {31'h0, bus.mem_req}, 0);

    // Both ports held for 6 cycles.
    c = cyc; busy_len = 0; rd_xor = 8'h00;
    bus.f_addr = 8'h40; bus.d_addr = 8'h50; bus.d_we = 1'b0;
    bus.f_req = 1'b1; bus.d_req = 1'b1;
`ifdef MEM_ARB_RR_EN
    push(1, 0, c + 2, 8'h50); push(0, 0, c + 4, 8'h40); push(1, 0, c + 6, 8'h50);
    f_rd_m = 8'h40;
`else
    push(1, 0, c + 2, 8'h50); push(1, 0, c + 4, 8'h50); push(1, 0, c + 6, 8'h50);
`endif
    d_rd_m = 8'h50;
    tick(1);
    check("both_f_stall", {31'h0, bus.f_stall}, 1);
    check("both_d_stall", {31'h0, bus.d_stall}, 1);
    tick(1);
    check("both_f_stall_c2", {31'h0, bus.f_stall}, 1);
    tick(4);
    bus.f_req = 1'b0; bus.d_req = 1'b0;
    tick(1);

    // Store with 3 busy cycles.
    c = cyc; busy_len = 3;
    bus.d_addr = 8'h20; bus.d_wdata = 8'h3C; bus.d_we = 1'b1; bus.d_req = 1'b1;
    push(1, 0, c + 5, d_rd_m);
    tick(1);
    check("store_mem_we", {31'h0, bus.mem_we}, 1);
    check("store_mem_addr", {24'h0, bus.mem_addr}, 32'h20);
    check("store_mem_wdata", {24'h0, bus.mem_wdata}, 32'h3C);
    tick(4);
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    tick(1);

    // Fetch request dropped while memory is busy.
    c = cyc; busy_len = 2; rd_xor = 8'h0F;
    bus.f_addr = 8'h77; bus.f_req = 1'b1;
    push(0, 0, c + 4, 8'h78); f_rd_m = 8'h78;
    tick(1);
    bus.f_req = 1'b0;
    tick(4);

    // Load with TIMEOUT-1 busy cycles completes normally.
    c = cyc; busy_len = 14; rd_xor = 8'h11;
    bus.d_addr = 8'h61; bus.d_we = 1'b0; bus.d_req = 1'b1;
    push(1, 0, c + 16, 8'h70); d_rd_m = 8'h70;
    tick(16);
    bus.d_req = 1'b0;
    tick(1);

    // Load with memory stuck busy times out.
    c = cyc; busy_len = 1000;
    bus.d_addr = 8'h62; bus.d_req = 1'b1;
    push(2, 1, c + 16, d_rd_m);
    tick(16);
    bus.d_req = 1'b0; busy_len = 0;
    tick(1);
    check("timeout_err_port_held", {31'h0, bus.err_port}, 1);
    check("timeout_idle", {31'h0, bus.mem_req}, 0);

    // err_port survives a later successful fetch.
    c = cyc; rd_xor = 8'h00;
    bus.f_addr = 8'h11; bus.f_req = 1'b1;
    push(0, 0, c + 2, 8'h11); f_rd_m = 8'h11;
    tick(2);
    check("err_port_still_held", {31'h0, bus.err_port}, 1);
    bus.f_req = 1'b0;
    tick(1);

    // Reset during the second busy cycle of a fetch.
    busy_len = 1000;
    bus.f_addr = 8'h33; bus.f_req = 1'b1;
    tick(2);
    reset = 1'b1; bus.f_req = 1'b0;
    tick(1);
    check("rst_mid_mem_req", {31'h0, bus.mem_req}, 0);
    check("rst_mid_f_done", {31'h0, bus.f_done}, 0);
    check("rst_mid_err", {31'h0, bus.err}, 0);
    check("rst_mid_f_rdata", {24'h0, bus.f_rdata}, 0);
    check("rst_mid_d_rdata", {24'h0, bus.d_rdata}, 0);
    check("rst_mid_mem_addr", {24'h0, bus.mem_addr}, 0);
    check("rst_mid_mem_wdata", {24'h0, bus.mem_wdata}, 0);
    check("rst_mid_err_port", {31'h0, bus.err_port}, 0);
    reset = 1'b0; busy_len = 0; f_rd_m = 8'h00; d_rd_m = 8'h00;
    tick(2);
    check("rst_mid_stays_idle", {31'h0, bus.mem_req}, 0);

    // Load after reset.
    c = cyc; rd_xor = 8'h0F;
    bus.d_addr = 8'h20; bus.d_we = 1'b0; bus.d_req = 1'b1;
    push(1, 0, c + 2, 8'h2F); d_rd_m = 8'h2F;
    tick(2);
    bus.d_req = 1'b0;
    tick(2);

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
